uart_oversample_sampler: RTL and testbench

//   Parametrised oversampling bit sampler for the UART RX path. Synchronises raw RX data.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_ff_chain.sv | 29 ++
 rtl/uart_oversample_sampler.sv | 145 ++++++++++++++
 tb/tb_uart_oversample_sampler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART oversampling sampler: FSM states, decision-phase math, voting.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sampler_state_e;

    localparam int MAX_VOTE = 32;

    // Phase at which the last sample of the centred window has been shifted in.
    function automatic int decision_phase(input int os, input int vw, input int cp);
        return (cp + vw / 2) % os;
    endfunction

    // True when that phase lies in the second bit period, so the first match after RUN entry is too early.
    function automatic logic decision_waits_wrap(input int os, input int vw, input int cp);
        return (cp + vw / 2) >= os;
    endfunction

    function automatic int popcount(input logic [MAX_VOTE-1:0] win);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_VOTE; i++) begin
            if (win[i]) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic majority_vote(input logic [MAX_VOTE-1:0] win, input int width);
        return popcount(win) >= (width + 1) / 2;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Input synchroniser: DEPTH flops on clk_i, cleared by rst_i; DEPTH=0 passes d_i straight through.
module sync_ff_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [DEPTH-1:0] chain_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= (chain_q << 1) | DEPTH'(d_i);
                end
            end

            assign q_o = chain_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/uart_oversample_sampler.sv
// UART RX oversampling sampler: majority vote around a programmable phase, frame bit tracking.
// Define UART_SAMPLER_NOISE_FLAG_EN to build the non-unanimous-window noise flag; otherwise it is tied 0.
module uart_oversample_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int VOTE_WIDTH   = 5,
    parameter int CENTER_PHASE = 15,
    parameter int FRAME_BITS   = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            raw_data,
    output logic                            estimated_data,
    output logic                            estimate_ready,
    output logic [$clog2(FRAME_BITS+1)-1:0] bit_index,
    output logic                            frame_done,
    output logic                            noise_detected
);

    localparam int              PW         = $clog2(OVERSAMPLE);
    localparam int              BW         = $clog2(FRAME_BITS + 1);
    localparam logic [PW-1:0]   DEC_PHASE  = PW'(decision_phase(OVERSAMPLE, VOTE_WIDTH, CENTER_PHASE));
    localparam logic            WAIT_WRAP  = decision_waits_wrap(OVERSAMPLE, VOTE_WIDTH, CENTER_PHASE);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]   LAST_BIT   = BW'(FRAME_BITS - 1);

    sampler_state_e        state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  wrapped_q, wrapped_d;
    logic [VOTE_WIDTH-1:0] window_q, window_d, win_next;
    logic [BW-1:0]         est_cnt_q, est_cnt_d;
    logic [BW-1:0]         bit_index_q, bit_index_d;
    logic                  data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  sd, decide, vote;

    sync_ff_chain #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (raw_data),
        .q_o   (sd)
    );

    // The vote sees the sample arriving in the decision cycle, so the window is centred on CENTER_PHASE.
    assign win_next = (window_q << 1) | VOTE_WIDTH'(sd);
    assign vote     = majority_vote(MAX_VOTE'(win_next), VOTE_WIDTH);
    assign decide   = (state_q == RUN) && enable && (phase_q == DEC_PHASE) && (wrapped_q || !WAIT_WRAP);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        wrapped_d   = wrapped_q;
        window_d    = window_q;
        est_cnt_d   = est_cnt_q;
        bit_index_d = bit_index_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        if ((state_q == IDLE) || !enable) begin
            phase_d     = '0;
            wrapped_d   = 1'b0;
            window_d    = '0;
            est_cnt_d   = '0;
            bit_index_d = '0;
        end
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    phase_d   = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
                    wrapped_d = wrapped_q | (phase_q == LAST_PHASE);
                    window_d  = win_next;
                    if (decide) begin
                        ready_d     = 1'b1;
                        data_d      = vote;
                        bit_index_d = est_cnt_q;
                        est_cnt_d   = est_cnt_q + BW'(1);
                        if (est_cnt_q == LAST_BIT) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_SAMPLER_NOISE_FLAG_EN
    logic noise_q, noise_d;
    int   ones;

    always_comb begin
        ones    = popcount(MAX_VOTE'(win_next));
        noise_d = decide && (ones != 0) && (ones != VOTE_WIDTH);
    end

    assign noise_detected = noise_q;
`else
    assign noise_detected = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            wrapped_q   <= 1'b0;
            window_q    <= '0;
            est_cnt_q   <= '0;
            bit_index_q <= '0;
            data_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_SAMPLER_NOISE_FLAG_EN
            noise_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wrapped_q   <= wrapped_d;
            window_q    <= window_d;
            est_cnt_q   <= est_cnt_d;
            bit_index_q <= bit_index_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
`ifdef UART_SAMPLER_NOISE_FLAG_EN
            noise_q     <= noise_d;
`endif
        end
    end

    assign estimated_data = data_q;
    assign estimate_ready = ready_q;
    assign bit_index      = bit_index_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_uart_oversample_sampler.sv
// Bench for uart_oversample_sampler: per-cycle reference model on the default instance plus directed literal checks.
module tb_uart_oversample_sampler;

    localparam int OS = 16, VW = 5, CP = 15, FB = 10, S = 2;
    localparam int BW = $clog2(FB + 1);
    localparam int FIRST_DEC = CP + VW / 2;
`ifdef UART_SAMPLER_NOISE_FLAG_EN
    localparam bit NOISE_EN = 1'b1;
`else
    localparam bit NOISE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0, raw_data = 1'b1;
    logic est_data, est_rdy, frm_done, noise;
    logic [BW-1:0] bit_idx;
    logic enable_b = 1'b0, raw_b = 1'b1;
    logic est_data_b, est_rdy_b, frm_done_b, noise_b;
    logic [1:0] bit_idx_b;

    int n_checks = 0, n_errs = 0;

    uart_oversample_sampler dut (
        .clk(clk), .rst(rst), .enable(enable), .raw_data(raw_data),
        .estimated_data(est_data), .estimate_ready(est_rdy), .bit_index(bit_idx),
        .frame_done(frm_done), .noise_detected(noise)
    );

    uart_oversample_sampler #(.OVERSAMPLE(8), .VOTE_WIDTH(3), .CENTER_PHASE(4), .FRAME_BITS(3)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .raw_data(raw_b),
        .estimated_data(est_data_b), .estimate_ready(est_rdy_b), .bit_index(bit_idx_b),
        .frame_done(frm_done_b), .noise_detected(noise_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sd is raw_data delayed S cycles; estimates at run cycle FIRST_DEC + k*OS.
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_e;
    mmode_e m_mode;
    int     m_n, m_cnt, ones;
    logic   rq[$];
    logic   win[$];
    logic   sdv;
    logic   exp_rdy, exp_dat, exp_done, exp_noise;
    logic [BW-1:0] exp_idx;

    task automatic model_reset();
        m_mode = M_IDLE; m_n = 0; m_cnt = 0;
        rq.delete(); win.delete();
        for (int i = 0; i < S; i++) rq.push_back(1'b0);
        exp_rdy = 0; exp_dat = 0; exp_done = 0; exp_noise = 0; exp_idx = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                if (S == 0) sdv = raw_data;
                else begin
                    sdv = rq.pop_front();
                    rq.push_back(raw_data);
                end
                exp_rdy = 0; exp_done = 0; exp_noise = 0;
                case (m_mode)
                    M_IDLE: if (enable) begin
                        m_mode = M_RUN; m_n = 0; m_cnt = 0; win.delete();
                    end
                    M_RUN: if (!enable) begin
                        m_mode = M_IDLE; exp_idx = '0;
                    end else begin
                        win.push_back(sdv);
                        if (m_n == FIRST_DEC + m_cnt * OS) begin
                            ones = 0;
                            for (int i = 0; i < VW; i++)
                                if (win.size() - 1 - i >= 0 && win[win.size() - 1 - i]) ones++;
                            exp_rdy   = 1;
                            exp_dat   = (ones >= (VW + 1) / 2);
                            exp_idx   = BW'(m_cnt);
                            exp_done  = (m_cnt == FB - 1);
                            exp_noise = NOISE_EN && ones > 0 && ones < VW;
                            m_cnt++;
                            if (m_cnt == FB) m_mode = M_DONE;
                        end
                        m_n++;
                    end
                    M_DONE: if (!enable) begin
                        m_mode = M_IDLE; exp_idx = '0;
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("estimate_ready", est_rdy, exp_rdy);
            check("estimated_data", est_data, exp_dat);
            check("bit_index", bit_idx, exp_idx);
            check("frame_done", frm_done, exp_done);
            check("noise_detected", noise, exp_noise);
        end
    end

    // Line level seen on sd in run cycle n; bit k spans n = 16k+8 .. 16k+23, centred on the vote window.
    function automatic logic line_val(input int mode, input int n);
        logic [7:0] byte_v;
        int k, off;
        logic v;
        byte_v = 8'h55;
        if (mode == 0 || n < 8) return 1'b1;
        k = (n - 8) / 16;
        off = (n - 8) % 16;
        if (k >= 10) return 1'b1;
        if (k == 0) v = 1'b0;
        else if (k == 9) v = 1'b1;
        else v = byte_v[k-1];
        if (mode == 2 && (k % 2 == 1) && (off == 6 || off == 7)) v = ~v;
        return v;
    endfunction

    int   pulses[$];
    logic dats[$], noises[$];
    int   done_n;
    logic [BW-1:0] idx_at_dis, idx_after_dis;
    logic [15:0] pk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; enable rises now so the next cycle is n=0.
    task automatic run_seq(input int mode, input int ncyc, input int dis_at);
        pulses.delete(); dats.delete(); noises.delete(); done_n = -1;
        enable = 1'b1;
        raw_data = line_val(mode, S - 1);
        for (int n = 0; n < ncyc; n++) begin
            step();
            raw_data = line_val(mode, n + S);
            if (n == dis_at) enable = 1'b0;
            @(negedge clk);
            if (est_rdy) begin
                pulses.push_back(n); dats.push_back(est_data); noises.push_back(noise);
            end
            if (frm_done) done_n = n;
            if (n == dis_at) idx_at_dis = bit_idx;
            if (n == dis_at + 1) idx_after_dis = bit_idx;
        end
    endtask

    task automatic idle(input int c);
        step();
        enable = 1'b0; raw_data = 1'b1;
        repeat (c) step();
    endtask

    function automatic int pulse_at(input int i);
        return (i < pulses.size()) ? pulses[i] : -1;
    endfunction

    task automatic pack_dats();
        pk = '0;
        foreach (dats[i]) if (i < 16) pk[i] = dats[i];
    endtask

    task automatic pack_noises();
        pk = '0;
        foreach (noises[i]) if (i < 16) pk[i] = noises[i];
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("reset ready", est_rdy, 0);
        check("reset data", est_data, 0);
        check("reset index", bit_idx, 0);
        check("reset done", frm_done, 0);
        check("reset noise", noise, 0);
        rst = 1'b0;
        step(); step();

        // Steady mark line: ten estimates of 1.
        run_seq(0, 170, -1);
        check("t1 pulse count", pulses.size(), 10);
        check("t1 first pulse n", pulse_at(0), 18);
        check("t1 second pulse n", pulse_at(1), 34);
        check("t1 last pulse n", pulse_at(9), 162);
        check("t1 frame_done n", done_n, 162);
        pack_dats();
        check("t1 data bits", pk, 16'h03FF);
        idle(4);

        // 0x55 frame with start and stop bits.
        run_seq(1, 180, -1);
        pack_dats();
        check("t2 data bits", pk, 16'h02AA);
        pack_noises();
        check("t2 noise bits", pk, 16'h0000);
        idle(4);

        // Same frame, 2-sample glitch inside the window of every odd bit.
        run_seq(2, 180, -1);
        pack_dats();
        check("t3 data bits", pk, 16'h02AA);
        pack_noises();
        check("t3 noise bits", pk, NOISE_EN ? 16'h02AA : 16'h0000);
        idle(4);

        // enable drops at n=40, then a fresh start.
        run_seq(0, 45, 40);
        check("t4 pulse count", pulses.size(), 2);
        check("t4 last pulse n", pulse_at(1), 34);
        check("t4 index at drop", idx_at_dis, 1);
        check("t4 index after drop", idx_after_dis, 0);
        step();
        run_seq(0, 25, -1);
        check("t4 restart first pulse", pulse_at(0), 18);
        idle(4);

        // Asynchronous reset mid-frame.
        run_seq(0, 70, -1);
        check("t5 data before rst", est_data, 1);
        check("t5 index before rst", bit_idx, 3);
        step();
        #1 rst = 1'b1;
        #1;
        check("t5 rst ready", est_rdy, 0);
        check("t5 rst data", est_data, 0);
        check("t5 rst index", bit_idx, 0);
        check("t5 rst done", frm_done, 0);
        check("t5 rst noise", noise, 0);
        enable = 1'b0;
        repeat (2) step();
        #2 rst = 1'b0;
        step(); step();

        // Small configuration on the second instance.
        pulses.delete(); done_n = -1; pk = '0;
        enable_b = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (n == 30) enable_b = 1'b0;
            @(negedge clk);
            if (est_rdy_b) begin
                pk[2*pulses.size() +: 2] = bit_idx_b;
                pulses.push_back(n);
                check("t6 data", est_data_b, 1);
            end
            if (frm_done_b) done_n = n;
            if (n == 31) check("t6 index after disable", bit_idx_b, 0);
        end
        check("t6 pulse count", pulses.size(), 3);
        check("t6 first pulse n", pulse_at(0), 6);
        check("t6 second pulse n", pulse_at(1), 14);
        check("t6 third pulse n", pulse_at(2), 22);
        check("t6 frame_done n", done_n, 22);
        check("t6 indices", pk[5:0], 6'b10_01_00);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1);
    end

endmodule
